// File: rtl/fm_demod.sv
// Quadrature FM discriminator: d(n) = I(n-1)*Q(n) - Q(n-1)*I(n), smoothed by a
// 2^AVG_LOG2-tap moving average and saturated to a 19-bit message.
module fm_demod #(
  parameter int AVG_LOG2 = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic               in_valid,
  input  logic signed [9:0]  fcos_i,
  input  logic signed [9:0]  fsin_i,
  output logic signed [18:0] msg_o,
  output logic               out_valid,
  output logic               sat_o,
  output logic               locked_o
);
  localparam int W = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2+1)'(W - 1);
  localparam logic signed [23:0] MSG_MAX = 24'sd262143;
  localparam logic signed [23:0] MSG_MIN = -24'sd262144;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_nxt;

  logic signed [9:0]  prev_i, prev_q;
  logic signed [19:0] prod_a, prod_b;
  // [0] products hold a fresh d, [1] acc holds an output-eligible window, [2] msg_o fresh
  logic [2:0]         vld_pipe;
  logic signed [20:0] d_buf [W];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]  fill_cnt;
  logic signed [23:0] acc;

  logic               accept, elig;
  logic signed [20:0] d_new;
  logic signed [23:0] avg;

  assign accept = clken & in_valid;
  assign d_new  = {prod_a[19], prod_a} - {prod_b[19], prod_b};
  assign avg    = acc >>> AVG_LOG2;
  assign elig   = vld_pipe[0] & ((state == RUN) | (fill_cnt == LAST));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FILL;
      FILL:    if (vld_pipe[0] && fill_cnt == LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      prev_i   <= '0;
      prev_q   <= '0;
      prod_a   <= '0;
      prod_b   <= '0;
      vld_pipe <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      acc      <= '0;
      msg_o    <= '0;
      sat_o    <= 1'b0;
      for (int k = 0; k < W; k++) d_buf[k] <= '0;
    end else if (clken) begin
      state <= state_nxt;
      // stage 1: the first sample after reset only primes the history
      vld_pipe[0] <= in_valid & (state != IDLE);
      if (in_valid) begin
        prod_a <= 20'(prev_i) * 20'(fsin_i);
        prod_b <= 20'(prev_q) * 20'(fcos_i);
        prev_i <= fcos_i;
        prev_q <= fsin_i;
      end
      // stage 2: window update, oldest entry leaves as the new one lands
      vld_pipe[1] <= elig;
      if (vld_pipe[0]) begin
        d_buf[wr_ptr] <= d_new;
        acc    <= acc + {{3{d_new[20]}}, d_new} - {{3{d_buf[wr_ptr][20]}}, d_buf[wr_ptr]};
        wr_ptr <= wr_ptr + 1'b1;
        if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
      end
      // stage 3: scale and clip
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        if (avg > MSG_MAX) begin
          msg_o <= MSG_MAX[18:0];
          sat_o <= 1'b1;
        end else if (avg < MSG_MIN) begin
          msg_o <= MSG_MIN[18:0];
          sat_o <= 1'b1;
        end else begin
          msg_o <= avg[18:0];
          sat_o <= 1'b0;
        end
      end
    end
  end

  // a registered pulse stays hidden while frozen and shows once clocking resumes
  assign out_valid = vld_pipe[2] & clken;
  assign locked_o  = (state == RUN);
endmodule

// File: tb/tb_fm_demod.sv
// Directed + random bench for fm_demod, checked against a sample-history model
// (discriminator values, floor-mean of the last W, clip) with explicit timing.
module tb_fm_demod;
  localparam int AL = 3;
  localparam int W  = 1 << AL;

  logic clk = 1'b0, reset_n = 1'b0, clken = 1'b0, in_valid = 1'b0;
  logic signed [9:0]  fcos_i = '0, fsin_i = '0;
  logic signed [18:0] msg_o;
  logic out_valid, sat_o, locked_o;

  fm_demod #(.AVG_LOG2(AL)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .in_valid(in_valid),
    .fcos_i(fcos_i), .fsin_i(fsin_i), .msg_o(msg_o), .out_valid(out_valid),
    .sat_o(sat_o), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct { int due; int msg; bit sat; } exp_t;
  exp_t eq[$];
  int  dq[$];
  bit  have_prev;
  int  pi, pq, dcount, en_cnt, lock_due, last_msg;
  bit  last_sat;
  int  pulses, obs_msg;
  bit  obs_sat;

  int rot_i[4] = '{100, 0, -100, 0};
  int rot_q[4] = '{0, 100, 0, -100};
  int sat_i[4] = '{511, -511, -511, 511};
  int sat_q[4] = '{511, 511, -511, -511};

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_avg(input int s);
    int q;
    q = s / W;
    if ((s % W) != 0 && s < 0) q--;
    return q;
  endfunction

  task automatic model_reset();
    have_prev = 0; dq.delete(); eq.delete();
    dcount = 0; lock_due = 0; last_msg = 0; last_sat = 0;
  endtask

  task automatic model_accept(input int i, input int q);
    int s, a;
    exp_t e;
    if (have_prev) begin
      dq.push_back(pi * q - pq * i);
      if (dq.size() > W) void'(dq.pop_front());
      dcount++;
      if (dcount == W) lock_due = en_cnt + 1;
      if (dcount >= W) begin
        s = 0;
        foreach (dq[j]) s += dq[j];
        a = floor_avg(s);
        e.due = en_cnt + 2;
        e.sat = (a > 262143) || (a < -262144);
        e.msg = (a > 262143) ? 262143 : (a < -262144) ? -262144 : a;
        eq.push_back(e);
      end
    end
    pi = i; pq = q; have_prev = 1;
  endtask

  task automatic step(input bit ce, input bit rn, input bit v, input int i, input int q);
    bit due;
    clken = ce; reset_n = rn; in_valid = v;
    fcos_i = 10'(i); fsin_i = 10'(q);
    #1;
    due = (eq.size() > 0) && (eq[0].due == en_cnt);
    chk("out_valid", {31'b0, out_valid}, {31'b0, due && ce});
    if (due) begin
      chk("msg_o", $signed(msg_o), eq[0].msg);
      chk("sat_o", {31'b0, sat_o}, {31'b0, eq[0].sat});
    end else begin
      chk("msg_hold", $signed(msg_o), last_msg);
      chk("sat_hold", {31'b0, sat_o}, {31'b0, last_sat});
    end
    chk("locked_o", {31'b0, locked_o}, {31'b0, (dcount >= W) && (en_cnt >= lock_due)});
    if (out_valid) begin
      pulses++; obs_msg = $signed(msg_o); obs_sat = sat_o;
    end
    @(posedge clk);
    if (!rn) model_reset();
    else if (ce) begin
      en_cnt++;
      if (due) begin
        last_msg = eq[0].msg; last_sat = eq[0].sat;
        void'(eq.pop_front());
      end
      if (v) model_accept(i, q);
    end
    #1;
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, $urandom_range(0, 1), rnd_s(), rnd_s());
  endtask

  initial begin
    en_cnt = 0;
    model_reset();
    // reset two cycles with random inputs
    clken = 1'b1; in_valid = 1'b1; fcos_i = 10'(rnd_s()); fsin_i = 10'(rnd_s());
    @(posedge clk); #1;
    step($urandom_range(0, 1), 0, 1, rnd_s(), rnd_s());
    chk("rst_msg", $signed(msg_o), 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_sat", {31'b0, sat_o}, 0);
    chk("rst_locked", {31'b0, locked_o}, 0);

    // constant phase
    pulses = 0;
    repeat (12) step(1, 1, 1, 100, 0);
    idle(4);
    chk("const_pulses", pulses, 4);
    chk("const_msg", obs_msg, 0);
    chk("const_locked", {31'b0, locked_o}, 1);

    // +90 and -90 degree rotation
    do_reset(); pulses = 0;
    for (int n = 0; n < 12; n++) step(1, 1, 1, rot_i[n % 4], rot_q[n % 4]);
    idle(4);
    chk("rot_pulses", pulses, 4);
    chk("rot_msg", obs_msg, 10000);
    do_reset();
    for (int n = 0; n < 12; n++) step(1, 1, 1, rot_i[(4 - n % 4) % 4], rot_q[(4 - n % 4) % 4]);
    idle(4);
    chk("rot_rev_msg", obs_msg, -10000);

    // saturation both ways
    do_reset();
    for (int n = 0; n < 12; n++) step(1, 1, 1, sat_i[n % 4], sat_q[n % 4]);
    idle(4);
    chk("sat_hi_msg", obs_msg, 262143);
    chk("sat_hi_flag", {31'b0, obs_sat}, 1);
    do_reset();
    for (int n = 0; n < 12; n++) step(1, 1, 1, sat_i[(4 - n % 4) % 4], sat_q[(4 - n % 4) % 4]);
    idle(4);
    chk("sat_lo_msg", obs_msg, -262144);
    chk("sat_lo_flag", {31'b0, obs_sat}, 1);

    // clock-enable stall and in_valid gaps
    do_reset(); pulses = 0;
    for (int n = 0; n < 12; n++) begin
      if (n == 10) repeat (5) step(0, 1, $urandom_range(0, 1), rnd_s(), rnd_s());
      if (n % 3 == 2) step(1, 1, 0, rnd_s(), rnd_s());
      step(1, 1, 1, rot_i[n % 4], rot_q[n % 4]);
    end
    idle(6);
    chk("stall_pulses", pulses, 4);
    chk("stall_msg", obs_msg, 10000);

    // reset in the middle of RUN
    do_reset();
    for (int n = 0; n < 12; n++) step(1, 1, 1, rot_i[n % 4], rot_q[n % 4]);
    step(1, 0, 1, rot_i[0], rot_q[0]);
    chk("midrst_msg", $signed(msg_o), 0);
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_locked", {31'b0, locked_o}, 0);
    pulses = 0;
    for (int n = 0; n < 8; n++) step(1, 1, 1, rot_i[n % 4], rot_q[n % 4]);
    idle(4);
    chk("midrst_none", pulses, 0);
    step(1, 1, 1, rot_i[0], rot_q[0]);
    idle(4);
    chk("midrst_first", pulses, 1);
    chk("midrst_val", obs_msg, 10000);

    // random traffic
    do_reset();
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 199) != 0,
           $urandom_range(0, 9) < 7, rnd_s(), rnd_s());
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fm_demod.md
FM_DEMOD -- requirements
Module: fm_demod

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, log2 of moving-average window W = 2^AVG_LOG2; legal range 1..4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port clken  input  1  global clock enable; low freezes all internal state.
REQ-005 SHALL have port in_valid  input  1  qualifies fcos_i/fsin_i; sample accepted when clken=1 and in_valid=1.
REQ-006 SHALL have port fcos_i  input  10  in-phase sample I, two's complement.
REQ-007 SHALL have port fsin_i  input  10  quadrature sample Q, two's complement.
REQ-008 SHALL have port msg_o  output  19  recovered message, two's complement, saturated.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse qualifying msg_o and sat_o.
REQ-010 SHALL have port sat_o  output  1  high with out_valid when the msg_o value was clipped.
REQ-011 SHALL have port locked_o  output  1  high while FSM is in RUN.

Function
REQ-012 SHALL implement FSM states IDLE (no previous sample), FILL (fewer than W discriminator values in window), RUN.
REQ-013 SHALL transition IDLE->FILL on first accepted sample; that sample only primes prev_i/prev_q and produces no discriminator value.
REQ-014 SHALL, for every later accepted sample n, compute d(n) = prev_i*Q(n) - prev_q*I(n) at full precision, 21-bit signed, then load prev_i/prev_q with I(n)/Q(n).
REQ-015 SHALL hold d values in a W-entry circular buffer with write pointer wrapping W-1 -> 0; 24-bit signed running sum acc updated acc <= acc + d(new) - d(oldest overwritten), with buffer entries 0 after reset.
REQ-016 SHALL count d values in FILL; transition FILL->RUN when the W-th d value enters the window; RUN persists until reset.
REQ-017 SHALL compute avg = acc arithmetically shifted right by AVG_LOG2, then saturate to [-262144, 262143]; sat_o=1 iff clipping occurred.
REQ-018 SHALL pipeline as: edge 1 capture sample and products, edge 2 subtract and update window/acc, edge 3 register msg_o/sat_o/out_valid; latency 3 enabled cycles from acceptance to out_valid.
REQ-019 SHALL assert out_valid only for samples whose d completes or follows a full window, i.e. first pulse for the (W+1)-th accepted sample after reset; one pulse per accepted sample thereafter.
REQ-020 SHALL, when clken=0, hold all pipeline, buffer, FSM, msg_o, sat_o; drive out_valid=0; resume from the exact frozen state when clken returns to 1.
REQ-021 SHALL retain prev_i/prev_q across in_valid gaps of any length; gaps insert no d value.
REQ-022 SHALL hold msg_o and sat_o at last valid values between out_valid pulses.
REQ-023 SHALL accept back-to-back samples every enabled cycle without stalls; there is no backpressure.

Reset
REQ-024 SHALL, when reset_n=0 at a rising edge regardless of clken, clear msg_o=0, out_valid=0, sat_o=0, locked_o=0, acc=0, buffer, pointer, fill counter, prev_i/prev_q, pipeline valid bits, and enter IDLE.
REQ-025 SHALL discard in-flight pipeline samples on reset mid-operation; no out_valid pulse follows reset until W+1 new samples are accepted.

Verification
REQ-026 Reset: reset_n=0 two cycles with random inputs -> msg_o=0, out_valid=0, sat_o=0, locked_o=0.
REQ-027 Constant phase: W=8, 12 samples I=100, Q=0, clken=1 -> first out_valid 3 cycles after 9th sample, msg_o=0, sat_o=0; locked_o high; 4 pulses total.
REQ-028 +90 deg rotation: repeat (100,0),(0,100),(-100,0),(0,-100), 12 samples -> every d=10000, msg_o=10000; reversed sequence -> msg_o=-10000.
REQ-029 Saturation: repeat (511,511),(-511,511),(-511,-511),(511,-511) -> d=522242, msg_o=262143, sat_o=1; reversed order -> msg_o=-262144, sat_o=1.
REQ-030 Stall/gaps: REQ-028 stream with clken=0 for 5 cycles mid-pipeline and in_valid=0 gaps -> identical msg_o sequence, out_valid=0 during stall, no extra pulses.
REQ-031 Reset mid-RUN: one-cycle reset_n=0 during REQ-028 stream -> outputs cleared next edge, locked_o=0, no out_valid until 9th post-reset sample plus 3 cycles.
